// File: rtl/dsp_mac_nch.sv
// dsp_mac_nch: multi-channel multiply-accumulate engine sharing one multiplier.
// Three pipeline stages plus an output register, all stalled together by output backpressure.

module dsp_mac_nch #(
  parameter int unsigned A_WIDTH   = 20,
  parameter int unsigned B_WIDTH   = 18,
  parameter int unsigned ACC_WIDTH = 64,
  parameter int unsigned Z_WIDTH   = 38,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [A_WIDTH-1:0]   A,
  input  logic [B_WIDTH-1:0]   B,
  input  logic [CH_W-1:0]      CH,
  input  logic                 UNSIGNED_A,
  input  logic                 UNSIGNED_B,
  input  logic                 SUBTRACT,
  input  logic                 LOAD_ACC,
  input  logic                 LAST,
  input  logic [5:0]           SHIFT_RIGHT,
  input  logic                 ROUND,
  input  logic                 SATURATE,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [Z_WIDTH-1:0]   Z,
  output logic [CH_W-1:0]      Z_CH,
  output logic                 OVERFLOW
);

  localparam int unsigned PW = A_WIDTH + B_WIDTH + 2;
  localparam int unsigned EW = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;
  localparam int unsigned M  = ACC_WIDTH - 1;
  localparam int unsigned IW = $clog2(ACC_WIDTH);
  localparam logic [CH_W:0] NumChW = (CH_W + 1)'(NUM_CH);

  // Clamp limits held at the rounding width (ACC_WIDTH+1).
  localparam logic signed [ACC_WIDTH:0] UMax = ~({(ACC_WIDTH + 1){1'b1}} << Z_WIDTH);
  localparam logic signed [ACC_WIDTH:0] SMax = ~({(ACC_WIDTH + 1){1'b1}} << (Z_WIDTH - 1));
  localparam logic signed [ACC_WIDTH:0] SMin = {(ACC_WIDTH + 1){1'b1}} << (Z_WIDTH - 1);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            ua;
    logic            ub;
    logic            sub;
    logic            load;
    logic            last;
    logic [5:0]      sh;
    logic            rnd;
    logic            sat;
  } ctrl_t;

  logic                        adv;
  ctrl_t                       in_ctrl;
  logic                        s1_valid_q, s2_valid_q, s3_valid_q;
  ctrl_t                       s1_ctrl_q, s2_ctrl_q, s3_ctrl_q;
  logic [A_WIDTH-1:0]          s1_a_q;
  logic [B_WIDTH-1:0]          s1_b_q;
  logic signed [A_WIDTH:0]     s2_a_q;
  logic signed [B_WIDTH:0]     s2_b_q;
  logic [ACC_WIDTH-1:0]        s3_prod_q;
  logic [ACC_WIDTH-1:0]        acc_q [NUM_CH];
  logic [NUM_CH-1:0]           ovf_q;
  logic                        out_valid_q;
  logic [Z_WIDTH-1:0]          z_q;
  logic [CH_W-1:0]             z_ch_q;
  logic                        ovf_out_q;

  logic signed [A_WIDTH:0]     ext_a;
  logic signed [B_WIDTH:0]     ext_b;
  logic signed [PW-1:0]        prod_full;
  logic signed [EW-1:0]        prod_ext;
  logic [ACC_WIDTH-1:0]        base;
  logic [ACC_WIDTH-1:0]        acc_new;
  logic                        ovf_cur;
  logic                        ovf_new;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic                        rbit;
  logic [IW-1:0]               ridx;
  logic signed [ACC_WIDTH:0]   rounded;
  logic [Z_WIDTH-1:0]          z_new;

  assign adv       = !out_valid_q || OUT_READY;
  assign IN_READY  = adv || !RESET_N;
  assign OUT_VALID = out_valid_q;
  assign Z         = z_q;
  assign Z_CH      = z_ch_q;
  assign OVERFLOW  = ovf_out_q;

  always_comb begin
    in_ctrl      = '0;
    in_ctrl.ch   = CH;
    in_ctrl.ua   = UNSIGNED_A;
    in_ctrl.ub   = UNSIGNED_B;
    in_ctrl.sub  = SUBTRACT;
    in_ctrl.load = LOAD_ACC;
    in_ctrl.last = LAST;
    in_ctrl.sh   = SHIFT_RIGHT;
    in_ctrl.rnd  = ROUND;
    in_ctrl.sat  = SATURATE;
  end

  // One extra bit per operand lets signed and unsigned share one signed multiplier.
  assign ext_a     = {~s1_ctrl_q.ua & s1_a_q[A_WIDTH-1], s1_a_q};
  assign ext_b     = {~s1_ctrl_q.ub & s1_b_q[B_WIDTH-1], s1_b_q};
  assign prod_full = PW'(s2_a_q) * PW'(s2_b_q);
  assign prod_ext  = EW'(prod_full);

  always_comb begin
    base    = s3_ctrl_q.load ? '0 : acc_q[s3_ctrl_q.ch];
    acc_new = '0;
    ovf_cur = 1'b0;
    if (s3_ctrl_q.sub) begin
      acc_new = base - s3_prod_q;
      ovf_cur = (base[M] != s3_prod_q[M]) && (acc_new[M] != base[M]);
    end else begin
      acc_new = base + s3_prod_q;
      ovf_cur = (base[M] == s3_prod_q[M]) && (acc_new[M] != base[M]);
    end
    ovf_new = (!s3_ctrl_q.load && ovf_q[s3_ctrl_q.ch]) || ovf_cur;
  end

  always_comb begin
    shifted = $signed(acc_new) >>> s3_ctrl_q.sh;
    ridx    = IW'(s3_ctrl_q.sh - 6'd1);
    rbit    = 1'b0;
    if (32'(s3_ctrl_q.sh) >= ACC_WIDTH) begin
      shifted = {ACC_WIDTH{acc_new[M]}};
      rbit    = acc_new[M];
    end else if (s3_ctrl_q.sh != 6'd0) begin
      rbit = acc_new[ridx];
    end
    if (!s3_ctrl_q.rnd) rbit = 1'b0;
    rounded = (ACC_WIDTH + 1)'(shifted) + {{ACC_WIDTH{1'b0}}, rbit};

    z_new = rounded[Z_WIDTH-1:0];
    if (s3_ctrl_q.sat) begin
      if (s3_ctrl_q.ua && s3_ctrl_q.ub) begin
        if (rounded[ACC_WIDTH])   z_new = '0;
        else if (rounded > UMax)  z_new = UMax[Z_WIDTH-1:0];
      end else begin
        if (rounded > SMax)       z_new = SMax[Z_WIDTH-1:0];
        else if (rounded < SMin)  z_new = SMin[Z_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s1_ctrl_q   <= '0;
      s2_ctrl_q   <= '0;
      s3_ctrl_q   <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s3_prod_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      z_ch_q      <= '0;
      ovf_out_q   <= 1'b0;
    end else if (adv) begin
      // Out-of-range channels travel as bubbles.
      s1_valid_q <= IN_VALID && ({1'b0, CH} < NumChW);
      s1_ctrl_q  <= in_ctrl;
      s1_a_q     <= A;
      s1_b_q     <= B;
      s2_valid_q <= s1_valid_q;
      s2_ctrl_q  <= s1_ctrl_q;
      s2_a_q     <= ext_a;
      s2_b_q     <= ext_b;
      s3_valid_q <= s2_valid_q;
      s3_ctrl_q  <= s2_ctrl_q;
      s3_prod_q  <= prod_ext[ACC_WIDTH-1:0];
      if (s3_valid_q) begin
        acc_q[s3_ctrl_q.ch] <= acc_new;
        ovf_q[s3_ctrl_q.ch] <= ovf_new;
      end
      out_valid_q <= s3_valid_q && s3_ctrl_q.last;
      if (s3_valid_q && s3_ctrl_q.last) begin
        z_q       <= z_new;
        z_ch_q    <= s3_ctrl_q.ch;
        ovf_out_q <= ovf_new;
      end
    end
  end

endmodule
